// File: rtl/arb_pkg.sv
// Shared constants for the arbitrating bus mux: arbitration mode codes and
// the width helper used to size grant indices.
package arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Constant function; evaluated at elaboration to size index ports.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way arbiter with a one-hot grant: fixed priority (ch0 highest) or round
// robin starting from an internal pointer that advances past each winner.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CH-1:0]           req,
  input  logic                      en,
  output logic [N_CH-1:0]           grant,
  output logic [clog2(N_CH)-1:0]    grant_idx
);

  localparam int IDX_W = clog2(N_CH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CH - 1);

  logic [IDX_W-1:0] ptr;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin : pick
    logic             found;
    logic [IDX_W-1:0] c;
    found     = 1'b0;
    c         = '0;
    grant     = '0;
    grant_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ARB_MODE == ARB_RR) c = IDX_W'((int'(ptr) + i) % N_CH);
      else                    c = IDX_W'(i);
      if (en && !found && req[c]) begin
        found     = 1'b1;
        grant[c]  = 1'b1;
        grant_idx = c;
      end
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (|grant) begin
      ptr <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/arb_mux_nbus.sv
// N-channel, WIDTH-bit arbitrating bus mux with valid/ready on every input
// and a registered valid/ready output stage.
module arb_mux_nbus
  import arb_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int WIDTH    = 8,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_CH*WIDTH-1:0]     i_data,
  input  logic [N_CH-1:0]           i_valid,
  output logic [N_CH-1:0]           o_ready,
  output logic [WIDTH-1:0]          o_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [clog2(N_CH)-1:0]    o_grant_idx
);

  localparam int IDX_W = clog2(N_CH);

  logic             load;
  logic [N_CH-1:0]  grant;
  logic [IDX_W-1:0] grant_idx;
  logic [WIDTH-1:0] sel_data;

  // The output register can take a word when empty or being drained; reset
  // gates the arbiter so no channel sees o_ready while held in reset.
  assign load    = !o_valid || i_ready;
  assign o_ready = grant;

  rr_arbiter #(
    .N_CH     (N_CH),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .req       (i_valid),
    .en        (load && i_rst_n),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // One-hot AND-OR select: no priority chain, grant is already one-hot.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      sel_data = sel_data | (i_data[k*WIDTH +: WIDTH] & {WIDTH{grant[k]}});
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_grant_idx <= '0;
    end else if (load) begin
      if (|grant) begin
        o_valid     <= 1'b1;
        o_data      <= sel_data;
        o_grant_idx <= grant_idx;
      end else begin
        o_valid     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_nbus.sv
// Directed bench for arb_mux_nbus: a round-robin instance and a
// fixed-priority instance, checked against hand-computed expectations.
module tb_arb_mux_nbus;

  logic       clk;
  logic       rst_n;

  logic [31:0] rr_data;
  logic [3:0]  rr_valid;
  logic [3:0]  rr_o_ready;
  logic [7:0]  rr_o_data;
  logic        rr_o_valid;
  logic        rr_ready;
  logic [1:0]  rr_idx;

  logic [31:0] fp_data;
  logic [3:0]  fp_valid;
  logic [3:0]  fp_o_ready;
  logic [7:0]  fp_o_data;
  logic        fp_o_valid;
  logic        fp_ready;
  logic [1:0]  fp_idx;

  int n_vec;
  int n_err;

  localparam logic [31:0] BASE = 32'hA3A2A1A0;

  arb_mux_nbus #(.N_CH(4), .WIDTH(8), .ARB_MODE(1)) dut_rr (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_data      (rr_data),
    .i_valid     (rr_valid),
    .o_ready     (rr_o_ready),
    .o_data      (rr_o_data),
    .o_valid     (rr_o_valid),
    .i_ready     (rr_ready),
    .o_grant_idx (rr_idx)
  );

  arb_mux_nbus #(.N_CH(4), .WIDTH(8), .ARB_MODE(0)) dut_fp (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_data      (fp_data),
    .i_valid     (fp_valid),
    .o_ready     (fp_o_ready),
    .o_data      (fp_o_data),
    .o_valid     (fp_o_valid),
    .i_ready     (fp_ready),
    .o_grant_idx (fp_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    rr_data  = BASE;
    rr_valid = 4'b1111;
    rr_ready = 1'b1;
    fp_data  = 32'hF3F2F1F0;
    fp_valid = 4'b0000;
    fp_ready = 1'b1;

    // 1. Reset with all channels requesting.
    #3;
    check("rst_valid", 32'(rr_o_valid), 'h0);
    check("rst_data",  32'(rr_o_data),  'h00);
    check("rst_ready", 32'(rr_o_ready), 'h0);
    tick();
    check("rst_ready_edge", 32'(rr_o_ready), 'h0);
    check("rst_idx",        32'(rr_idx),     'h0);
    rst_n = 1'b1;
    #1;
    check("first_grant", 32'(rr_o_ready), 'b0001);

    // 2. Round robin at full throughput.
    tick();
    check("rr0_data",  32'(rr_o_data),  'hA0);
    check("rr0_idx",   32'(rr_idx),     'h0);
    check("rr0_valid", 32'(rr_o_valid), 'h1);
    check("rr0_ready", 32'(rr_o_ready), 'b0010);
    tick(); check("rr1_data", 32'(rr_o_data), 'hA1);
    tick(); check("rr2_data", 32'(rr_o_data), 'hA2);
    tick(); check("rr3_data", 32'(rr_o_data), 'hA3);
    check("rr3_idx", 32'(rr_idx), 'h3);
    tick(); check("rr4_data", 32'(rr_o_data), 'hA0);

    // 3. Stall holding 8'h55; ch1 is next in line so its word becomes 55.
    rr_data = 32'hA3A255A0;
    tick();
    rr_ready = 1'b0;
    #1;
    check("stall_entry_data", 32'(rr_o_data), 'h55);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) rr_data = 32'hA3C255A0;
      if (i == 3) rr_valid = 4'b0001;
      if (i == 4) rr_valid = 4'b1111;
      tick();
      check("stall_data",  32'(rr_o_data),  'h55);
      check("stall_valid", 32'(rr_o_valid), 'h1);
      check("stall_ready", 32'(rr_o_ready), 'b0000);
      check("stall_idx",   32'(rr_idx),     'h1);
    end
    rr_ready = 1'b1;
    #1;
    check("unstall_ready", 32'(rr_o_ready), 'b0100);
    tick();
    check("unstall_data", 32'(rr_o_data), 'hC2);
    check("unstall_idx",  32'(rr_idx),    'h2);

    // 4. Wrap: pointer now 3, only ch1 requests.
    rr_data  = BASE;
    rr_valid = 4'b0010;
    #1;
    check("wrap_ready", 32'(rr_o_ready), 'b0010);
    tick();
    check("wrap_idx",  32'(rr_idx),    'h1);
    check("wrap_data", 32'(rr_o_data), 'hA1);
    rr_valid = 4'b0110;
    #1;
    check("wrap_next_ready", 32'(rr_o_ready), 'b0100);
    tick();
    check("wrap_next_idx", 32'(rr_idx), 'h2);

    // Load with nothing pending: valid drops, data and index hold.
    rr_valid = 4'b0000;
    #1;
    check("idle_ready", 32'(rr_o_ready), 'b0000);
    tick();
    check("idle_valid", 32'(rr_o_valid), 'h0);
    check("idle_data",  32'(rr_o_data),  'hA2);
    check("idle_idx",   32'(rr_idx),     'h2);

    // 6. Reset mid-stream with a held word.
    rr_valid = 4'b1111;
    rr_ready = 1'b0;
    tick();
    check("pre_rst_data",  32'(rr_o_data),  'hA3);
    check("pre_rst_valid", 32'(rr_o_valid), 'h1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(rr_o_valid), 'h0);
    check("async_rst_data",  32'(rr_o_data),  'h00);
    check("async_rst_ready", 32'(rr_o_ready), 'b0000);
    tick();
    rst_n    = 1'b1;
    rr_valid = 4'b0100;
    #1;
    check("post_rst_ready", 32'(rr_o_ready), 'b0100);
    tick();
    check("post_rst_idx",  32'(rr_idx),    'h2);
    check("post_rst_data", 32'(rr_o_data), 'hA2);
    // Pointer should now be 3: ch3 beats ch0.
    rr_ready = 1'b1;
    rr_valid = 4'b1001;
    #1;
    check("post_rst_ptr", 32'(rr_o_ready), 'b1000);

    // 5. Fixed priority: ch1 always beats ch3.
    fp_valid = 4'b1010;
    #1;
    check("fp_ready0", 32'(fp_o_ready), 'b0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fp_data",  32'(fp_o_data),  'hF1);
      check("fp_idx",   32'(fp_idx),     'h1);
      check("fp_ready", 32'(fp_o_ready), 'b0010);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
